// File: rtl/checkpoint_pkg.sv
// rtl/checkpoint_pkg.sv - shared types and constants for the register checkpoint unit
//
// Purpose : register image, word and checkpoint id types plus register-file
//           geometry used by the checkpoint unit and its write-back merge.
// Ports   : none (package).
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package checkpoint_pkg;

   localparam int NUM_REGS      = 32;
   localparam int REG_ADDR_W    = 5;
   localparam int DEFAULT_DEPTH = 4;

   typedef logic [`DATA_WIDTH-1:0] reg_word_t;
   typedef reg_word_t reg_image_t [NUM_REGS];
   typedef logic [$clog2(DEFAULT_DEPTH)-1:0] ckpt_id_t;

endpackage

// File: rtl/ckpt_wb_merge.sv
// rtl/ckpt_wb_merge.sv - overlays a same-cycle write-back onto a register image
//
// Purpose : combinational image-plus-write-back overlay so a capture sees the
//           value being written in the same cycle it is taken.
// Ports   : i_image    - register image as currently held by the register file
//           i_wb_valid - write-back valid
//           i_wb_addr  - write-back register address (0 is not special)
//           i_wb_data  - write-back data
//           o_image    - merged image
module ckpt_wb_merge
   import checkpoint_pkg::*;
(
   input  reg_image_t             i_image,
   input  logic                   i_wb_valid,
   input  logic [REG_ADDR_W-1:0]  i_wb_addr,
   input  reg_word_t              i_wb_data,
   output reg_image_t             o_image
);

   always_comb begin
      for (int r = 0; r < NUM_REGS; r++) begin
         if (i_wb_valid && (i_wb_addr == REG_ADDR_W'(r))) begin
            o_image[r] = i_wb_data;
         end else begin
            o_image[r] = i_image[r];
         end
      end
   end

endmodule

// File: rtl/reg_checkpoint_unit.sv
// rtl/reg_checkpoint_unit.sv - branch checkpoint FIFO producing register-file restore images
//
// Purpose : captures full register images when a branch is predicted and, on a
//           mispredict of the oldest branch, drives a one-cycle restore pulse
//           with the pre-branch image.
// Ports   : clk, rst           - clock, synchronous active-high reset
//           i_regs             - current register image
//           i_wb_uses_rw/addr/data - same-cycle write-back merged into captures
//           take_ckpt          - capture request
//           ckpt_ready         - a free slot exists (registered count only)
//           ckpt_id            - id given to a capture accepted this cycle
//           resolve_valid/id/mispredict - oldest-branch resolution
//           recover_snapshot   - one-cycle restore pulse
//           regs_snapshot      - image to restore, held after the pulse
//           order_err          - sticky ordering / empty-resolve error
module reg_checkpoint_unit
   import checkpoint_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int ID_W  = $clog2(DEPTH)
)(
   input  logic                    clk,
   input  logic                    rst,
   input  reg_image_t              i_regs,
   input  logic                    i_wb_uses_rw,
   input  logic [4:0]              i_wb_rw_addr,
   input  logic [`DATA_WIDTH-1:0]  i_wb_rw_data,
   input  logic                    take_ckpt,
   output logic                    ckpt_ready,
   output logic [ID_W-1:0]         ckpt_id,
   input  logic                    resolve_valid,
   input  logic [ID_W-1:0]         resolve_id,
   input  logic                    resolve_mispredict,
   output logic                    recover_snapshot,
   output reg_image_t              regs_snapshot,
   output logic                    order_err
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [ID_W-1:0]  head_q, head_d;
   logic [ID_W-1:0]  tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             recover_q, recover_d;
   logic             order_err_q, order_err_d;
   reg_image_t       snap_q, snap_d;
   reg_image_t       slot_q [DEPTH];
   reg_image_t       slot_d [DEPTH];
   reg_image_t       merged_img;

   logic resolve_hit;
   logic mis_ok;
   logic cor_ok;
   logic take_ok;

   ckpt_wb_merge u_merge (
      .i_image    (i_regs),
      .i_wb_valid (i_wb_uses_rw),
      .i_wb_addr  (i_wb_rw_addr),
      .i_wb_data  (i_wb_rw_data),
      .o_image    (merged_img)
   );

   assign ckpt_ready       = (count_q != FULL_CNT);
   assign ckpt_id          = tail_q;
   assign recover_snapshot = recover_q;
   assign regs_snapshot    = snap_q;
   assign order_err        = order_err_q;

   always_comb begin
      head_d      = head_q;
      tail_d      = tail_q;
      count_d     = count_q;
      recover_d   = 1'b0;
      snap_d      = snap_q;
      order_err_d = order_err_q;

      // Only the oldest outstanding branch may resolve.
      resolve_hit = (resolve_id == head_q) && (count_q != '0);
      mis_ok      = resolve_valid &&  resolve_mispredict && resolve_hit;
      cor_ok      = resolve_valid && !resolve_mispredict && resolve_hit;
      // A capture alongside an accepted mispredict belongs to the flushed path.
      take_ok     = take_ckpt && ckpt_ready && !mis_ok;

      if (resolve_valid && !resolve_hit) begin
         order_err_d = 1'b1;
      end

      if (mis_ok) begin
         snap_d    = slot_q[head_q];
         recover_d = 1'b1;
         head_d    = tail_q;
         count_d   = '0;
      end else begin
         if (take_ok) begin
            tail_d = tail_q + ID_W'(1);
         end
         if (cor_ok) begin
            head_d = head_q + ID_W'(1);
         end
         unique case ({take_ok, cor_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_comb begin
      slot_d = slot_q;
      if (take_ok) begin
         slot_d[tail_q] = merged_img;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         recover_q   <= 1'b0;
         order_err_q <= 1'b0;
         snap_q      <= '{default: '0};
      end else begin
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         recover_q   <= recover_d;
         order_err_q <= order_err_d;
         snap_q      <= snap_d;
      end
   end

   // Slot contents need no reset; validity is tracked by head/tail/count.
   always_ff @(posedge clk) begin
      slot_q <= slot_d;
   end

endmodule

// File: tb/tb_reg_checkpoint_unit.sv
// tb/tb_reg_checkpoint_unit.sv - directed vector bench for reg_checkpoint_unit
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_reg_checkpoint_unit;
   import checkpoint_pkg::*;

   logic        clk;
   logic        rst;
   reg_image_t  i_regs;
   logic        i_wb_uses_rw;
   logic [4:0]  i_wb_rw_addr;
   logic [31:0] i_wb_rw_data;
   logic        take_ckpt;
   logic        ckpt_ready;
   logic [1:0]  ckpt_id;
   logic        resolve_valid;
   logic [1:0]  resolve_id;
   logic        resolve_mispredict;
   logic        recover_snapshot;
   reg_image_t  regs_snapshot;
   logic        order_err;

   int n_checks = 0;
   int n_fail   = 0;

   reg_checkpoint_unit #(.DEPTH(4)) dut (
      .clk                (clk),
      .rst                (rst),
      .i_regs             (i_regs),
      .i_wb_uses_rw       (i_wb_uses_rw),
      .i_wb_rw_addr       (i_wb_rw_addr),
      .i_wb_rw_data       (i_wb_rw_data),
      .take_ckpt          (take_ckpt),
      .ckpt_ready         (ckpt_ready),
      .ckpt_id            (ckpt_id),
      .resolve_valid      (resolve_valid),
      .resolve_id         (resolve_id),
      .resolve_mispredict (resolve_mispredict),
      .recover_snapshot   (recover_snapshot),
      .regs_snapshot      (regs_snapshot),
      .order_err          (order_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        take;
      logic        rv;
      logic        rmis;
      logic [1:0]  rid;
      logic        wbv;
      logic [4:0]  wba;
      logic [31:0] wbd;
      logic [31:0] base;
      logic        z5;
      logic        e_ready;
      logic [1:0]  e_id;
      logic        e_rec;
      logic        e_oerr;
      int          sidx;
      logic [31:0] sval;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic rst_i, take_i, rv_i, rmis_i, input logic [1:0] rid_i,
                      input logic wbv_i, input logic [4:0] wba_i, input logic [31:0] wbd_i,
                      input logic [31:0] base_i, input logic z5_i,
                      input logic e_ready_i, input logic [1:0] e_id_i,
                      input logic e_rec_i, e_oerr_i, input int sidx_i, input logic [31:0] sval_i);
      vec_t v;
      v.rst = rst_i;   v.take = take_i; v.rv = rv_i;   v.rmis = rmis_i; v.rid = rid_i;
      v.wbv = wbv_i;   v.wba = wba_i;   v.wbd = wbd_i; v.base = base_i; v.z5 = z5_i;
      v.e_ready = e_ready_i; v.e_id = e_id_i; v.e_rec = e_rec_i; v.e_oerr = e_oerr_i;
      v.sidx = sidx_i; v.sval = sval_i;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic set_regs(input logic [31:0] base, input logic z5);
      for (int r = 0; r < NUM_REGS; r++) i_regs[r] = base + 32'(4 * r);
      if (z5) i_regs[5] = '0;
   endtask

   task automatic idle_inputs();
      rst = 1'b0; take_ckpt = 1'b0; resolve_valid = 1'b0; resolve_mispredict = 1'b0;
      resolve_id = '0; i_wb_uses_rw = 1'b0; i_wb_rw_addr = '0; i_wb_rw_data = '0;
   endtask

   initial begin
      logic snap_zero;

      idle_inputs();
      set_regs(32'h0, 1'b0);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset ckpt_ready", 32'(ckpt_ready), 32'd1);
      check("reset ckpt_id", 32'(ckpt_id), 32'd0);
      check("reset recover_snapshot", 32'(recover_snapshot), 32'd0);
      check("reset order_err", 32'(order_err), 32'd0);
      snap_zero = 1'b1;
      for (int r = 0; r < NUM_REGS; r++) if (regs_snapshot[r] !== '0) snap_zero = 1'b0;
      check("reset regs_snapshot zero", 32'(snap_zero), 32'd1);

      //  rst tk rv mis rid wbv wba wbd           base      z5  rdy id rec oe sidx sval
      add(0, 1, 0, 0,  0,  0,  0, 32'h0,        32'h0,    0,  1, 0, 0, 0,  7, 32'h0);
      add(0, 0, 1, 1,  0,  0,  0, 32'h0,        32'h55,   0,  1, 1, 1, 0,  7, 32'd28);
      add(0, 0, 0, 0,  0,  0,  0, 32'h0,        32'h0,    0,  1, 1, 0, 0,  7, 32'd28);
      add(0, 1, 0, 0,  0,  1,  5, 32'hDEADBEEF, 32'h100,  1,  1, 1, 0, 0,  7, 32'd28);
      add(0, 0, 1, 1,  1,  1,  6, 32'h1234,     32'h900,  0,  1, 2, 1, 0,  5, 32'hDEADBEEF);
      add(0, 0, 0, 0,  0,  0,  0, 32'h0,        32'h0,    0,  1, 2, 0, 0,  6, 32'h118);
      add(0, 0, 0, 0,  0,  0,  0, 32'h0,        32'h0,    0,  1, 2, 0, 0,  0, 32'h100);
      add(1, 0, 0, 0,  0,  0,  0, 32'h0,        32'h0,    0,  1, 2, 0, 0,  5, 32'h0);
      add(0, 1, 0, 0,  0,  0,  0, 32'h0,        32'h1000, 0,  1, 0, 0, 0,  5, 32'h0);
      add(0, 1, 0, 0,  0,  0,  0, 32'h0,        32'h2000, 0,  1, 1, 0, 0,  5, 32'h0);
      add(0, 1, 0, 0,  0,  0,  0, 32'h0,        32'h3000, 0,  1, 2, 0, 0,  5, 32'h0);
      add(0, 1, 0, 0,  0,  0,  0, 32'h0,        32'h4000, 0,  1, 3, 0, 0,  5, 32'h0);
      add(0, 1, 0, 0,  0,  0,  0, 32'h0,        32'h5000, 0,  0, 0, 0, 0,  5, 32'h0);
      add(0, 1, 1, 0,  0,  0,  0, 32'h0,        32'h5000, 0,  0, 0, 0, 0,  5, 32'h0);
      add(0, 1, 0, 0,  0,  0,  0, 32'h0,        32'h6000, 0,  1, 0, 0, 0,  5, 32'h0);
      add(0, 0, 0, 0,  0,  0,  0, 32'h0,        32'h0,    0,  0, 1, 0, 0,  5, 32'h0);
      add(0, 0, 1, 1,  1,  0,  0, 32'h0,        32'h0,    0,  0, 1, 1, 0,  3, 32'h200C);
      add(1, 0, 0, 0,  0,  0,  0, 32'h0,        32'h0,    0,  1, 1, 0, 0,  3, 32'h0);
      add(0, 1, 0, 0,  0,  0,  0, 32'h0,        32'hA000, 0,  1, 0, 0, 0,  3, 32'h0);
      add(0, 1, 0, 0,  0,  0,  0, 32'h0,        32'hB000, 0,  1, 1, 0, 0,  3, 32'h0);
      add(0, 1, 1, 0,  0,  0,  0, 32'h0,        32'hC000, 0,  1, 2, 0, 0,  3, 32'h0);
      add(0, 0, 0, 0,  0,  0,  0, 32'h0,        32'h0,    0,  1, 3, 0, 0,  3, 32'h0);
      add(0, 0, 1, 0,  2,  0,  0, 32'h0,        32'h0,    0,  1, 3, 0, 1,  3, 32'h0);
      add(0, 0, 0, 0,  0,  0,  0, 32'h0,        32'h0,    0,  1, 3, 0, 1,  3, 32'h0);
      add(0, 0, 1, 1,  1,  0,  0, 32'h0,        32'h0,    0,  1, 3, 1, 1, 31, 32'hB07C);
      add(0, 0, 1, 1,  3,  0,  0, 32'h0,        32'h0,    0,  1, 3, 0, 1, 31, 32'hB07C);
      add(0, 1, 0, 0,  0,  0,  0, 32'h0,        32'hD000, 0,  1, 3, 0, 1, 31, 32'hB07C);
      add(0, 1, 1, 1,  3,  0,  0, 32'h0,        32'hE000, 0,  1, 0, 1, 1,  2, 32'hD008);
      add(0, 0, 0, 0,  0,  0,  0, 32'h0,        32'h0,    0,  1, 0, 0, 1,  2, 32'hD008);
      add(0, 1, 0, 0,  0,  0,  0, 32'h0,        32'hF000, 0,  1, 0, 0, 1,  2, 32'hD008);
      add(1, 0, 1, 1,  0,  0,  0, 32'h0,        32'h0,    0,  1, 1, 0, 0,  2, 32'h0);
      add(0, 0, 0, 0,  0,  0,  0, 32'h0,        32'h0,    0,  1, 0, 0, 0,  2, 32'h0);

      foreach (vecs[i]) begin
         @(negedge clk);
         rst                = vecs[i].rst;
         take_ckpt          = vecs[i].take;
         resolve_valid      = vecs[i].rv;
         resolve_mispredict = vecs[i].rmis;
         resolve_id         = vecs[i].rid;
         i_wb_uses_rw       = vecs[i].wbv;
         i_wb_rw_addr       = vecs[i].wba;
         i_wb_rw_data       = vecs[i].wbd;
         set_regs(vecs[i].base, vecs[i].z5);
         #1;
         check($sformatf("v%0d ckpt_ready", i), 32'(ckpt_ready), 32'(vecs[i].e_ready));
         check($sformatf("v%0d ckpt_id", i), 32'(ckpt_id), 32'(vecs[i].e_id));
         @(posedge clk);
         #1;
         check($sformatf("v%0d recover_snapshot", i), 32'(recover_snapshot), 32'(vecs[i].e_rec));
         check($sformatf("v%0d order_err", i), 32'(order_err), 32'(vecs[i].e_oerr));
         check($sformatf("v%0d regs_snapshot[%0d]", i, vecs[i].sidx),
               regs_snapshot[vecs[i].sidx], vecs[i].sval);
      end

      // Full-image restore with a write-back to register 0 merged at capture.
      @(negedge clk);
      idle_inputs();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      take_ckpt = 1'b1;
      set_regs(32'h300, 1'b0);
      i_wb_uses_rw = 1'b1; i_wb_rw_addr = 5'd0; i_wb_rw_data = 32'h77;
      @(negedge clk);
      idle_inputs();
      set_regs(32'h7700, 1'b0);
      resolve_valid = 1'b1; resolve_mispredict = 1'b1; resolve_id = 2'd0;
      @(posedge clk);
      #1;
      check("full restore pulse", 32'(recover_snapshot), 32'd1);
      for (int r = 0; r < NUM_REGS; r++) begin
         check($sformatf("full restore reg%0d", r), regs_snapshot[r],
               (r == 0) ? 32'h77 : 32'h300 + 32'(4 * r));
      end
      @(negedge clk);
      idle_inputs();
      @(posedge clk);
      #1;
      check("full restore pulse single cycle", 32'(recover_snapshot), 32'd0);
      check("full restore ready after flush", 32'(ckpt_ready), 32'd1);
      check("full restore held reg1", regs_snapshot[1], 32'h304);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
